mac_pipelined_dotprod: RTL and testbench

//  Parametrised two-stage pipelined multiply-accumulate unit computing dot products of

---
 rtl/mac_pipelined_dotprod.sv | 175 +++++++++++++++++
 tb/tb_mac_pipelined_dotprod.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipelined_dotprod.sv
// ---------------------------------------------------------------------------
// mac_pipelined_dotprod
//
// Two-stage pipelined multiply-accumulate engine that produces one dot product
// per frame of TERMS operand pairs. Stage 1 registers the full-precision
// product a*b; stage 2 folds it into the running accumulator. Frame boundaries
// come from an internal term counter, so operands only need a valid strobe.
// Signed/unsigned operation and wrap/saturate behaviour are parameters.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears every register
//   clear         synchronous frame abort; a same-cycle valid input becomes
//                 term 0 of the new frame
//   in_valid      a/b valid this cycle (always accepted, no backpressure)
//   a, b          operands, IN_W bits
//   acc_out       running accumulator of the current frame
//   term_idx      number of terms accepted so far in the current frame
//   result        last completed dot product, held until the next frame ends
//   result_valid  one-cycle pulse when result is updated
//   overflow      wrap/saturation occurred in the frame reported by result
// ---------------------------------------------------------------------------
module mac_pipelined_dotprod #(
    parameter int IN_W     = 16,
    parameter int ACC_W    = 36,
    parameter int TERMS    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0,
    localparam int CNT_W   = $clog2(TERMS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_idx,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    generate
        if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
            $error("mac_pipelined_dotprod: ACC_W must be >= 2*IN_W");
        end
        if (TERMS < 1) begin : g_bad_terms
            $error("mac_pipelined_dotprod: TERMS must be >= 1");
        end
    endgenerate

    localparam logic IS_SIGNED = (SIGNED != 0);
    localparam logic IS_SAT    = (SATURATE != 0);

    // ------------------------------------------------------------------
    // Stage 1: product register and term counter
    // ------------------------------------------------------------------
    logic [2*IN_W-1:0] p1_reg;
    logic              v1_reg;
    logic              last1_reg;
    logic [CNT_W-1:0]  term_idx_reg;

    // One extra bit lets a single signed multiplier serve both modes: the
    // extension bit is the operand MSB in signed mode and zero otherwise.
    logic signed [IN_W:0]     a_ext;
    logic signed [IN_W:0]     b_ext;
    logic signed [2*IN_W-1:0] prod;
    logic [CNT_W-1:0]         cur_idx;
    logic                     is_last;
    logic [CNT_W-1:0]         idx_next;

    assign a_ext = $signed({IS_SIGNED & a[IN_W-1], a});
    assign b_ext = $signed({IS_SIGNED & b[IN_W-1], b});
    // Product of two (IN_W+1)-bit values always fits in 2*IN_W bits for
    // either mode, so truncating the context width loses nothing.
    assign prod  = a_ext * b_ext;

    // A clear restarts numbering, so a same-cycle input is term 0.
    assign cur_idx  = clear ? '0 : term_idx_reg;
    assign is_last  = (cur_idx == CNT_W'(TERMS - 1));
    assign idx_next = is_last ? '0 : cur_idx + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_reg       <= '0;
            v1_reg       <= 1'b0;
            last1_reg    <= 1'b0;
            term_idx_reg <= '0;
        end else begin
            v1_reg <= in_valid;
            if (in_valid) begin
                p1_reg       <= prod;
                last1_reg    <= is_last;
                term_idx_reg <= idx_next;
            end else begin
                last1_reg    <= 1'b0;
                term_idx_reg <= cur_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate, overflow detection, frame completion
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_f_reg;
    logic [ACC_W-1:0] result_reg;
    logic             overflow_reg;
    logic             result_valid_reg;

    logic signed [2*IN_W:0] p_s;
    logic [ACC_W-1:0]       p_ext;
    logic [ACC_W:0]         sum_full;
    logic                   carry;
    logic                   s_ovf;
    logic                   this_ovf;
    logic [ACC_W-1:0]       sat_val;
    logic [ACC_W-1:0]       sum_c;

    assign p_s      = $signed({IS_SIGNED & p1_reg[2*IN_W-1], p1_reg});
    assign p_ext    = ACC_W'(p_s);
    assign sum_full = {1'b0, acc_reg} + {1'b0, p_ext};
    assign carry    = sum_full[ACC_W];
    assign s_ovf    = (acc_reg[ACC_W-1] == p_ext[ACC_W-1]) &&
                      (sum_full[ACC_W-1] != acc_reg[ACC_W-1]);
    assign this_ovf = IS_SIGNED ? s_ovf : carry;

    // Signed overflow only happens when both addends share a sign, so the
    // accumulator sign tells which rail to clamp to.
    always_comb begin
        sat_val = '1;
        if (IS_SIGNED) begin
            sat_val = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign sum_c = (IS_SAT && this_ovf) ? sat_val : sum_full[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg          <= '0;
            ovf_f_reg        <= 1'b0;
            result_reg       <= '0;
            overflow_reg     <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            if (clear) begin
                // In-flight product is dropped; result/overflow keep the last frame.
                acc_reg   <= '0;
                ovf_f_reg <= 1'b0;
            end else if (v1_reg) begin
                if (last1_reg) begin
                    result_reg       <= sum_c;
                    overflow_reg     <= ovf_f_reg | this_ovf;
                    result_valid_reg <= 1'b1;
                    acc_reg          <= '0;
                    ovf_f_reg        <= 1'b0;
                end else begin
                    acc_reg   <= sum_c;
                    ovf_f_reg <= ovf_f_reg | this_ovf;
                end
            end
        end
    end

    assign acc_out      = acc_reg;
    assign term_idx     = term_idx_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_mac_pipelined_dotprod.sv
// ---------------------------------------------------------------------------
// tb_mac_pipelined_dotprod
//
// Five instances with different parameter sets share clk/reset/clear/a/b and
// each has its own in_valid. Expected results (value, overflow flag and the
// cycle on which the pulse must appear) are queued when the last term of a
// frame is driven and popped when any instance pulses result_valid.
//   0: TERMS=4 unsigned ACC_W=36      1: TERMS=2 signed ACC_W=36
//   2: TERMS=2 unsigned ACC_W=32 wrap 3: TERMS=2 unsigned ACC_W=32 saturate
//   4: TERMS=1 unsigned ACC_W=36
// ---------------------------------------------------------------------------
module tb_mac_pipelined_dotprod;

    localparam int NDUT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            clear;
    logic [15:0]     a;
    logic [15:0]     b;
    logic [NDUT-1:0] vld;
    logic [NDUT-1:0] rv;
    logic [NDUT-1:0] ov;

    logic [35:0] acc0, res0, acc1, res1, acc4, res4;
    logic [31:0] acc2, res2, acc3, res3;
    logic [2:0]  ti0;
    logic [1:0]  ti1, ti2, ti3;
    logic [0:0]  ti4;
    logic [63:0] res_w [NDUT];

    assign res_w[0] = {28'd0, res0};
    assign res_w[1] = {28'd0, res1};
    assign res_w[2] = {32'd0, res2};
    assign res_w[3] = {32'd0, res3};
    assign res_w[4] = {28'd0, res4};

    mac_pipelined_dotprod #(.IN_W(16), .ACC_W(36), .TERMS(4), .SIGNED(0), .SATURATE(0)) u_main (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(vld[0]), .a(a), .b(b),
        .acc_out(acc0), .term_idx(ti0), .result(res0), .result_valid(rv[0]), .overflow(ov[0]));
    mac_pipelined_dotprod #(.IN_W(16), .ACC_W(36), .TERMS(2), .SIGNED(1), .SATURATE(0)) u_sgn (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(vld[1]), .a(a), .b(b),
        .acc_out(acc1), .term_idx(ti1), .result(res1), .result_valid(rv[1]), .overflow(ov[1]));
    mac_pipelined_dotprod #(.IN_W(16), .ACC_W(32), .TERMS(2), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(vld[2]), .a(a), .b(b),
        .acc_out(acc2), .term_idx(ti2), .result(res2), .result_valid(rv[2]), .overflow(ov[2]));
    mac_pipelined_dotprod #(.IN_W(16), .ACC_W(32), .TERMS(2), .SIGNED(0), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(vld[3]), .a(a), .b(b),
        .acc_out(acc3), .term_idx(ti3), .result(res3), .result_valid(rv[3]), .overflow(ov[3]));
    mac_pipelined_dotprod #(.IN_W(16), .ACC_W(36), .TERMS(1), .SIGNED(0), .SATURATE(0)) u_one (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(vld[4]), .a(a), .b(b),
        .acc_out(acc4), .term_idx(ti4), .result(res4), .result_valid(rv[4]), .overflow(ov[4]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    typedef struct {
        int          dut;
        logic [63:0] val;
        logic        ovf;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Called while the last term is on the inputs: sampled on the next edge,
    // result visible after the edge after that.
    task automatic push_exp(input int d, input logic [63:0] v, input logic o);
        exp_t e;
        e.dut = d; e.val = v; e.ovf = o; e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [15:0] aa, input logic [15:0] bb);
        a = aa; b = bb;
        vld = '0;
        vld[d] = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        vld = '0; a = '0; b = '0;
        repeat (n) step();
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rv[d]) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_pulse_dut%0d", d), 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("pulse dut%0d cycle %0d result=%0h overflow=%0b", d, cyc, res_w[d], ov[d]);
                    chk("pulse_dut", 64'(d), 64'(e.dut));
                    chk("result", res_w[d], e.val);
                    chk("overflow", 64'(ov[d]), 64'(e.ovf));
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [63:0] sum;
    logic [15:0] ra, rb;
    logic [63:0] last_rand;

    initial begin
        // 1: reset held with valid inputs present
        reset = 1'b1; clear = 1'b0; a = 16'd5; b = 16'd5; vld = '1;
        repeat (3) step();
        chk("rst_acc0", 64'(acc0), 64'd0);
        chk("rst_ti0", 64'(ti0), 64'd0);
        chk("rst_res0", 64'(res0), 64'd0);
        chk("rst_ovf", 64'(ov), 64'd0);
        chk("rst_rv", 64'(rv), 64'd0);
        chk("rst_acc_other", 64'(acc1 | 36'(acc2) | 36'(acc3) | acc4), 64'd0);
        chk("rst_ti_other", 64'({ti1, ti2, ti3, ti4}), 64'd0);
        vld = '0; a = '0; b = '0; reset = 1'b0;
        idle(1);

        // 2: 1,2,3,4 squared back-to-back
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) push_exp(0, 64'd30, 1'b0);
            drive(0, 16'(i), 16'(i));
        end
        idle(1);
        chk("acc_after_frame", 64'(acc0), 64'd0);
        chk("ti_after_frame", 64'(ti0), 64'd0);

        // 3: 2*3 x4 with a two-cycle gap; previous result must hold
        drive(0, 16'd2, 16'd3);
        drive(0, 16'd2, 16'd3);
        idle(2);
        chk("result_held", 64'(res0), 64'd30);
        chk("acc_mid_frame", 64'(acc0), 64'd12);
        drive(0, 16'd2, 16'd3);
        push_exp(0, 64'd24, 1'b0);
        drive(0, 16'd2, 16'd3);
        idle(3);

        // random unsigned frames with random gaps
        last_rand = '0;
        for (int f = 0; f < 3; f++) begin
            sum = '0;
            for (int t = 0; t < 4; t++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                sum = sum + 64'(ra) * 64'(rb);
                if (t == 3) push_exp(0, sum, 1'b0);
                drive(0, ra, rb);
                if ($urandom_range(0, 1) == 1) idle(1);
            end
            last_rand = sum;
            idle(2);
        end

        // 6: clear mid-frame with a same-cycle input
        drive(0, 16'd1, 16'd1);
        drive(0, 16'd1, 16'd1);
        clear = 1'b1;
        drive(0, 16'd2, 16'd2);
        clear = 1'b0;
        chk("clear_ti", 64'(ti0), 64'd1);
        chk("clear_res_held", 64'(res0), last_rand);
        drive(0, 16'd1, 16'd1);
        drive(0, 16'd1, 16'd1);
        push_exp(0, 64'd7, 1'b0);
        drive(0, 16'd1, 16'd1);
        idle(3);

        // 4: signed frames, including the most negative operands
        drive(1, 16'hFFFD, 16'd5);
        push_exp(1, 64'h0000_000F_FFFF_FFE3, 1'b0);
        drive(1, 16'd7, 16'hFFFE);
        drive(1, 16'h8000, 16'h8000);
        push_exp(1, 64'h0000_0000_8000_0000, 1'b0);
        drive(1, 16'h8000, 16'h8000);
        idle(3);

        // 5: wrap and saturate, then a clean frame clears the flag
        drive(2, 16'hFFFF, 16'hFFFF);
        push_exp(2, 64'hFFFC_0002, 1'b1);
        drive(2, 16'hFFFF, 16'hFFFF);
        drive(2, 16'd1, 16'd1);
        push_exp(2, 64'd2, 1'b0);
        drive(2, 16'd1, 16'd1);
        idle(3);
        drive(3, 16'hFFFF, 16'hFFFF);
        push_exp(3, 64'hFFFF_FFFF, 1'b1);
        drive(3, 16'hFFFF, 16'hFFFF);
        drive(3, 16'd1, 16'd1);
        push_exp(3, 64'd2, 1'b0);
        drive(3, 16'd1, 16'd1);
        idle(3);

        // TERMS=1: every input is a whole frame
        push_exp(4, 64'd12, 1'b0);
        drive(4, 16'd3, 16'd4);
        push_exp(4, 64'hFFFE_0001, 1'b0);
        drive(4, 16'hFFFF, 16'hFFFF);
        idle(3);

        // 6b: reset mid-frame discards everything
        drive(0, 16'd9, 16'd9);
        drive(0, 16'd9, 16'd9);
        vld = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        idle(3);
        chk("midrst_acc", 64'(acc0), 64'd0);
        chk("midrst_ti", 64'(ti0), 64'd0);
        chk("midrst_res", 64'(res0), 64'd0);
        chk("midrst_ovf", 64'(ov[0]), 64'd0);

        idle(3);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
